// File: rtl/comparator_4bit_reg_if.sv
// rtl/comparator_4bit_reg_if.sv - operand/flag/counter bundle for comparator_4bit_reg
//
// Purpose: groups the comparator's operand inputs, controls, flags and
//          counters so the compare unit and its user share one connection.
// Signals:
//   a, b      operands (master -> slave)
//   en        sample enable for registered path and counters
//   clr       synchronous counter clear
//   G, E, L   combinational a>b, a==b, a<b
//   G_r, E_r, L_r, vld_r, rel_chg   registered flags, valid, relation-change pulse
//   cnt_gt, cnt_eq, cnt_lt          saturating per-relation event counters
// Modports: master drives operands/controls; slave is the comparator.

interface comparator_4bit_reg_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             en;
    logic             clr;
    logic             G;
    logic             E;
    logic             L;
    logic             G_r;
    logic             E_r;
    logic             L_r;
    logic             vld_r;
    logic             rel_chg;
    logic [CNT_W-1:0] cnt_gt;
    logic [CNT_W-1:0] cnt_eq;
    logic [CNT_W-1:0] cnt_lt;

    modport master (
        output a, b, en, clr,
        input  G, E, L, G_r, E_r, L_r, vld_r, rel_chg, cnt_gt, cnt_eq, cnt_lt
    );

    modport slave (
        input  a, b, en, clr,
        output G, E, L, G_r, E_r, L_r, vld_r, rel_chg, cnt_gt, cnt_eq, cnt_lt
    );
endinterface

// File: rtl/comparator_4bit_reg.sv
// rtl/comparator_4bit_reg.sv - magnitude comparator with registered flags and event counters
//
// Purpose: compares two WIDTH-bit operands (unsigned or two's complement),
//          drives one-hot G/E/L combinationally, keeps an enable-qualified
//          registered copy, pulses rel_chg when the captured relation
//          changes, and counts captured relations in saturating counters.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset, clears all registered outputs
//   cmp_if  comparator_4bit_reg_if.slave (operands, controls, flags, counters)

module comparator_4bit_reg #(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    comparator_4bit_reg_if.slave cmp_if
);

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    localparam logic [WIDTH-1:0] KEY_FLIP = {(SIGNED != 0), {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_a_key;
    logic [WIDTH-1:0] w_b_key;
    logic             w_gt;
    logic             w_eq;
    logic             w_lt;
    logic [2:0]       w_rel;

    logic             r_g;
    logic             r_e;
    logic             r_l;
    logic             r_vld;
    logic             r_rel_chg;
    logic [CNT_W-1:0] r_cnt_gt;
    logic [CNT_W-1:0] r_cnt_eq;
    logic [CNT_W-1:0] r_cnt_lt;

    assign w_a_key = cmp_if.a ^ KEY_FLIP;
    assign w_b_key = cmp_if.b ^ KEY_FLIP;
    assign w_gt    = (w_a_key >  w_b_key);
    assign w_eq    = (w_a_key == w_b_key);
    assign w_lt    = (w_a_key <  w_b_key);
    assign w_rel   = {w_gt, w_eq, w_lt};

    // Registered flags, valid and relation-change pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g       <= 1'b0;
            r_e       <= 1'b0;
            r_l       <= 1'b0;
            r_vld     <= 1'b0;
            r_rel_chg <= 1'b0;
        end else begin
            // The pulse only compares against a real earlier capture; the
            // reset value 000 is not a relation.
            r_rel_chg <= cmp_if.en && r_vld && (w_rel != {r_g, r_e, r_l});
            if (cmp_if.en) begin
                r_g   <= w_gt;
                r_e   <= w_eq;
                r_l   <= w_lt;
                r_vld <= 1'b1;
            end
        end
    end

    // Saturating event counters; clear wins over a same-cycle capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_gt <= '0;
            r_cnt_eq <= '0;
            r_cnt_lt <= '0;
        end else if (cmp_if.clr) begin
            r_cnt_gt <= '0;
            r_cnt_eq <= '0;
            r_cnt_lt <= '0;
        end else if (cmp_if.en) begin
            if (w_gt && !(&r_cnt_gt)) r_cnt_gt <= r_cnt_gt + CNT_ONE;
            if (w_eq && !(&r_cnt_eq)) r_cnt_eq <= r_cnt_eq + CNT_ONE;
            if (w_lt && !(&r_cnt_lt)) r_cnt_lt <= r_cnt_lt + CNT_ONE;
        end
    end

    assign cmp_if.G       = w_gt;
    assign cmp_if.E       = w_eq;
    assign cmp_if.L       = w_lt;
    assign cmp_if.G_r     = r_g;
    assign cmp_if.E_r     = r_e;
    assign cmp_if.L_r     = r_l;
    assign cmp_if.vld_r   = r_vld;
    assign cmp_if.rel_chg = r_rel_chg;
    assign cmp_if.cnt_gt  = r_cnt_gt;
    assign cmp_if.cnt_eq  = r_cnt_eq;
    assign cmp_if.cnt_lt  = r_cnt_lt;

endmodule

// File: tb/tb_comparator_4bit_reg.sv
// tb/tb_comparator_4bit_reg.sv - directed self-checking bench for comparator_4bit_reg

module tb_comparator_4bit_reg;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    comparator_4bit_reg_if #(.WIDTH(4), .CNT_W(8)) u_if ();
    comparator_4bit_reg_if #(.WIDTH(4), .CNT_W(8)) s_if ();

    comparator_4bit_reg #(.WIDTH(4), .SIGNED(0), .CNT_W(8)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmp_if (u_if.slave)
    );

    comparator_4bit_reg #(.WIDTH(4), .SIGNED(1), .CNT_W(8)) s_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmp_if (s_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] u_flags();
        return {u_if.G, u_if.E, u_if.L};
    endfunction

    function automatic logic [2:0] u_regs();
        return {u_if.G_r, u_if.E_r, u_if.L_r};
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        u_if.a = 4'd0; u_if.b = 4'd0; u_if.en = 1'b0; u_if.clr = 1'b0;
        s_if.a = 4'd0; s_if.b = 4'd0; s_if.en = 1'b0; s_if.clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_regs",    u_regs(),       3'b000);
        check("rst_vld",     u_if.vld_r,     1'b0);
        check("rst_rel_chg", u_if.rel_chg,   1'b0);
        check("rst_cnt_gt",  u_if.cnt_gt,    8'd0);
        check("rst_cnt_eq",  u_if.cnt_eq,    8'd0);
        check("rst_cnt_lt",  u_if.cnt_lt,    8'd0);
        check("rst_comb_e",  u_flags(),      3'b010);
        @(negedge clk);
        rst_n = 1'b1;

        // a=5,b=3: greater
        u_if.a = 4'd5; u_if.b = 4'd3; u_if.en = 1'b1;
        #1;
        check("gt_comb", u_flags(), 3'b100);
        tick();
        check("gt_regs",    u_regs(),     3'b100);
        check("gt_vld",     u_if.vld_r,   1'b1);
        check("gt_cnt",     u_if.cnt_gt,  8'd1);
        check("gt_no_pulse_first", u_if.rel_chg, 1'b0);

        // a=7,b=7: equal, relation changed from G
        u_if.a = 4'd7; u_if.b = 4'd7;
        #1;
        check("eq_comb", u_flags(), 3'b010);
        tick();
        check("eq_regs",    u_regs(),     3'b010);
        check("eq_rel_chg", u_if.rel_chg, 1'b1);
        check("eq_cnt",     u_if.cnt_eq,  8'd1);

        // a=3,b=6: less, visible before any edge
        u_if.a = 4'd3; u_if.b = 4'd6;
        #1;
        check("lt_comb", u_flags(), 3'b001);
        tick();
        check("lt_regs",    u_regs(),     3'b001);
        check("lt_rel_chg", u_if.rel_chg, 1'b1);
        check("lt_cnt",     u_if.cnt_lt,  8'd1);

        // Combinational boundaries with capture disabled
        u_if.en = 1'b0;
        u_if.a = 4'd0;  u_if.b = 4'd15; #1; check("bnd_0_15",  u_flags(), 3'b001);
        u_if.a = 4'd15; u_if.b = 4'd0;  #1; check("bnd_15_0",  u_flags(), 3'b100);
        u_if.a = 4'd0;  u_if.b = 4'd0;  #1; check("bnd_0_0",   u_flags(), 3'b010);
        u_if.a = 4'd8;  u_if.b = 4'd7;  #1; check("uns_8_7",   u_flags(), 3'b100);
        s_if.a = 4'd8;  s_if.b = 4'd7;  #1; check("sgn_8_7",   {s_if.G, s_if.E, s_if.L}, 3'b001);
        s_if.a = 4'd7;  s_if.b = 4'd8;  #1; check("sgn_7_8",   {s_if.G, s_if.E, s_if.L}, 3'b100);
        s_if.a = 4'd15; s_if.b = 4'd0;  #1; check("sgn_m1_0",  {s_if.G, s_if.E, s_if.L}, 3'b001);

        // en=0 for 3 edges with changing inputs: registered state holds
        @(negedge clk);
        u_if.a = 4'd9;  u_if.b = 4'd2;  #1; check("hold_comb0", u_flags(), 3'b100);
        tick();
        @(negedge clk);
        u_if.a = 4'd4;  u_if.b = 4'd4;  #1; check("hold_comb1", u_flags(), 3'b010);
        tick();
        @(negedge clk);
        u_if.a = 4'd12; u_if.b = 4'd1;  #1; check("hold_comb2", u_flags(), 3'b100);
        tick();
        check("hold_regs",    u_regs(),     3'b001);
        check("hold_rel_chg", u_if.rel_chg, 1'b0);
        check("hold_cnts",    {u_if.cnt_gt, u_if.cnt_eq, u_if.cnt_lt}, {8'd1, 8'd1, 8'd1});

        // Same relation captured again: no pulse, counter advances
        @(negedge clk);
        u_if.a = 4'd3; u_if.b = 4'd6; u_if.en = 1'b1;
        tick();
        check("same_rel_chg", u_if.rel_chg, 1'b0);
        check("same_cnt_lt",  u_if.cnt_lt,  8'd2);

        // clr with en=1: counters zero, sample not counted, flags still captured
        @(negedge clk);
        u_if.a = 4'd5; u_if.b = 4'd3; u_if.clr = 1'b1;
        tick();
        check("clr_cnts",    {u_if.cnt_gt, u_if.cnt_eq, u_if.cnt_lt}, 24'd0);
        check("clr_regs",    u_regs(),     3'b100);
        check("clr_rel_chg", u_if.rel_chg, 1'b1);
        @(negedge clk);
        u_if.clr = 1'b0;

        // Saturation: 300 captures of a>b
        repeat (300) @(posedge clk);
        #1;
        check("sat_cnt_gt", u_if.cnt_gt, 8'd255);
        check("sat_cnt_eq", u_if.cnt_eq, 8'd0);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_regs",  u_regs(),   3'b000);
        check("arst_vld",   u_if.vld_r, 1'b0);
        check("arst_cnts",  {u_if.cnt_gt, u_if.cnt_eq, u_if.cnt_lt}, 24'd0);
        check("arst_comb",  u_flags(),  3'b100);
        @(negedge clk);
        rst_n = 1'b1;

        // First capture after reset never pulses
        u_if.a = 4'd0; u_if.b = 4'd0;
        tick();
        check("post_rst_rel_chg", u_if.rel_chg, 1'b0);
        check("post_rst_vld",     u_if.vld_r,   1'b1);
        check("post_rst_cnt_eq",  u_if.cnt_eq,  8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
